// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Round-robin arbiter for the single Common Data Bus shared by
//             N_UF functional units. One UF is granted per cycle and its
//             tag/data pair is broadcast on the registered CDB outputs. An
//             idle bus carries TAG_NONE / DATA_NONE.
//  Ports    : Clock        - rising-edge clock
//             Resetn       - asynchronous active-low reset
//             Flush        - drops the pending grant, idles the bus next cycle
//             Req          - per-UF request (valid result held)
//             Req_tag      - per-UF tag, UF i at [i*TAG_W +: TAG_W]
//             Req_data     - per-UF data, UF i at [i*DATA_W +: DATA_W]
//             Grant        - one-hot, one-cycle grant pulse
//             Qi_CDB       - broadcast tag
//             Qi_CDB_data  - broadcast data
//             CDB_valid    - bus carries a real result this cycle
//             Err_tag      - sticky: a request arrived with tag TAG_NONE
//  Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
   parameter int                N_UF      = 4,
   parameter int                TAG_W     = 3,
   parameter int                DATA_W    = 16,
   parameter logic [TAG_W-1:0]  TAG_NONE  = '0,
   parameter logic [DATA_W-1:0] DATA_NONE = 16'hFFF0
) (
   input  logic                   Clock,
   input  logic                   Resetn,
   input  logic                   Flush,
   input  logic [N_UF-1:0]        Req,
   input  logic [N_UF*TAG_W-1:0]  Req_tag,
   input  logic [N_UF*DATA_W-1:0] Req_data,
   output logic [N_UF-1:0]        Grant,
   output logic [TAG_W-1:0]       Qi_CDB,
   output logic [DATA_W-1:0]      Qi_CDB_data,
   output logic                   CDB_valid,
   output logic                   Err_tag
);

   localparam int PTR_W = (N_UF > 1) ? $clog2(N_UF) : 1;

   logic [TAG_W-1:0]  tag_arr  [N_UF];
   logic [DATA_W-1:0] data_arr [N_UF];
   logic [N_UF-1:0]   eligible;
   logic [N_UF-1:0]   illegal;

   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  winner;
   logic [PTR_W-1:0]  idx;
   logic [PTR_W-1:0]  next_ptr;
   logic              found;
   logic [N_UF-1:0]   grant_vec;

   // Unpack the flat request buses; a UF that was granted last cycle is
   // masked so its stale result cannot win again on the closing edge.
   generate
      for (genvar i = 0; i < N_UF; i++) begin : g_uf
         assign tag_arr[i]  = Req_tag[i*TAG_W +: TAG_W];
         assign data_arr[i] = Req_data[i*DATA_W +: DATA_W];
         assign eligible[i] = Req[i] & ~Grant[i] & (tag_arr[i] != TAG_NONE);
         assign illegal[i]  = Req[i] & (tag_arr[i] == TAG_NONE);
      end
   endgenerate

   // First eligible index scanning upward from rr_ptr with wrap-around.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int off = 0; off < N_UF; off++) begin
         idx = PTR_W'((int'(rr_ptr) + off) % N_UF);
         if (!found && eligible[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign next_ptr  = (winner == PTR_W'(N_UF - 1)) ? '0 : winner + PTR_W'(1);
   assign grant_vec = N_UF'(1) << winner;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         Grant       <= '0;
         CDB_valid   <= 1'b0;
         Qi_CDB      <= TAG_NONE;
         Qi_CDB_data <= DATA_NONE;
         Err_tag     <= 1'b0;
         rr_ptr      <= '0;
      end else begin
         Err_tag <= Err_tag | (|illegal);
         // Flush wins over any winner; the pointer only advances on a
         // grant that actually reaches the bus.
         if (Flush || !found) begin
            Grant       <= '0;
            CDB_valid   <= 1'b0;
            Qi_CDB      <= TAG_NONE;
            Qi_CDB_data <= DATA_NONE;
         end else begin
            Grant       <= grant_vec;
            CDB_valid   <= 1'b1;
            Qi_CDB      <= tag_arr[winner];
            Qi_CDB_data <= data_arr[winner];
            rr_ptr      <= next_ptr;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdb_arbiter
//  Purpose  : Self-checking bench for cdb_arbiter. A behavioural model
//             predicts the bus after every edge and queues the prediction;
//             the queue is drained and compared after the edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int TW = 3;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            flush;
   logic [N-1:0]    req;
   logic [N*TW-1:0] req_tag;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    grant;
   logic [TW-1:0]   qi_cdb;
   logic [DW-1:0]   qi_cdb_data;
   logic            cdb_valid;
   logic            err_tag;

   cdb_arbiter #(
      .N_UF(N), .TAG_W(TW), .DATA_W(DW),
      .TAG_NONE(3'b000), .DATA_NONE(16'hFFF0)
   ) dut (
      .Clock(clk), .Resetn(rst_n), .Flush(flush),
      .Req(req), .Req_tag(req_tag), .Req_data(req_data),
      .Grant(grant), .Qi_CDB(qi_cdb), .Qi_CDB_data(qi_cdb_data),
      .CDB_valid(cdb_valid), .Err_tag(err_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]  grant;
      logic          valid;
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
      logic          err;
   } exp_t;

   exp_t         sb[$];
   int           n_tests = 0;
   int           n_fail  = 0;
   int           m_ptr;
   logic [N-1:0] m_grant;
   logic         m_err;
   string        phase = "init";

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr   = 0;
      m_grant = '0;
      m_err   = 1'b0;
      sb.delete();
   endtask

   // Predict the bus after the coming edge from the current inputs.
   task automatic model_push();
      exp_t e;
      int   w;
      int   k;
      w       = -1;
      e.err   = m_err;
      e.grant = '0;
      e.valid = 1'b0;
      e.tag   = 3'b000;
      e.data  = 16'hFFF0;
      for (int i = 0; i < N; i++)
         if (req[i] && req_tag[i*TW +: TW] == 3'b000) e.err = 1'b1;
      for (int off = 0; off < N; off++) begin
         k = (m_ptr + off) % N;
         if (w < 0 && req[k] && !m_grant[k] && req_tag[k*TW +: TW] != 3'b000) w = k;
      end
      if (!flush && w >= 0) begin
         e.grant = N'(1) << w;
         e.valid = 1'b1;
         e.tag   = req_tag[w*TW +: TW];
         e.data  = req_data[w*DW +: DW];
         m_ptr   = (w + 1) % N;
      end
      m_grant = e.grant;
      m_err   = e.err;
      sb.push_back(e);
   endtask

   task automatic compare();
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_empty", 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check("grant", grant, e.grant);
         check("valid", cdb_valid, e.valid);
         check("tag", qi_cdb, e.tag);
         check("data", qi_cdb_data, e.data);
         check("err", err_tag, e.err);
      end
   endtask

   task automatic step();
      model_push();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic check_idle();
      check("idle_grant", grant, 4'b0000);
      check("idle_valid", cdb_valid, 1'b0);
      check("idle_tag", qi_cdb, 3'b000);
      check("idle_data", qi_cdb_data, 16'hFFF0);
   endtask

   task automatic set_uf(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
      req_tag[i*TW +: TW]  = t;
      req_data[i*DW +: DW] = d;
   endtask

   logic [N-1:0] rr_order [5];

   initial begin
      rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst_n = 1'b0;
      flush = 1'b0;
      req   = 4'b1111;
      for (int i = 0; i < N; i++) set_uf(i, TW'(i + 1), DW'(16'hA000 + i));

      // Reset held with every UF requesting: bus stays idle.
      phase = "reset";
      repeat (3) begin
         @(posedge clk);
         #1;
         check_idle();
         check("err", err_tag, 1'b0);
      end
      rst_n = 1'b1;
      model_reset();

      // Round robin with all four requesting.
      phase = "rr";
      for (int k = 0; k < 5; k++) begin
         step();
         check("order", grant, rr_order[k]);
      end
      req = '0;
      step();

      // Single request from UF2.
      phase = "single";
      req = 4'b0100;
      set_uf(2, 3'b011, 16'h0042);
      step();
      check("grant", grant, 4'b0100);
      check("tag", qi_cdb, 3'b011);
      check("data", qi_cdb_data, 16'h0042);
      check("valid", cdb_valid, 1'b1);
      req = '0;
      step();
      check_idle();

      // Illegal tag is never granted and sets the sticky error.
      phase = "illegal";
      req = 4'b0001;
      set_uf(0, 3'b000, 16'h0BAD);
      step();
      check("grant", grant, 4'b0000);
      check("err", err_tag, 1'b1);
      step();
      req = 4'b0010;
      set_uf(1, 3'b101, 16'h1234);
      step();
      check("grant", grant, 4'b0010);
      check("err", err_tag, 1'b1);
      req = '0;
      step();

      // Flush beats a simultaneous winner; the request is served afterwards.
      phase = "flush";
      req   = 4'b0010;
      set_uf(1, 3'b110, 16'h5555);
      flush = 1'b1;
      step();
      check_idle();
      flush = 1'b0;
      step();
      check("grant", grant, 4'b0010);
      check("data", qi_cdb_data, 16'h5555);
      req = '0;
      step();

      // Random traffic following the hold-until-granted handshake.
      phase = "random";
      for (int c = 0; c < 200; c++) begin
         for (int i = 0; i < N; i++) begin
            if (m_grant[i]) begin
               if ($urandom_range(0, 1) == 1) set_uf(i, TW'($urandom_range(1, 7)), DW'($urandom));
               else req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 9) < 4) begin
               req[i] = 1'b1;
               set_uf(i, TW'($urandom_range(1, 7)), DW'($urandom));
            end
         end
         flush = ($urandom_range(0, 9) == 0);
         step();
      end
      flush = 1'b0;

      // Asynchronous reset in the middle of a broadcast.
      phase = "reset_mid";
      req = 4'b1111;
      for (int i = 0; i < N; i++) set_uf(i, TW'(i + 1), DW'(16'hB000 + i));
      step();
      check("valid", cdb_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle();
      check("err", err_tag, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      check_idle();
      rst_n = 1'b1;
      step();
      check("first", grant, 4'b0001);
      check("tag", qi_cdb, 3'b001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
